// File: rtl/pwm_duty_ramp_if.sv
// pwm_duty_ramp_if: control/status bundle between the SPI register bank side
// (master) and the duty slew-rate limiter (slave).
//
// There is no valid/ready handshake on this bundle: ramp_en and target_duty
// are levels that the slave samples on every clock edge, and duty_out/busy/done
// are registered levels (done is a one-cycle pulse) that the master may sample
// at any time away from the clock edge.
interface pwm_duty_ramp_if;
    logic       ramp_en;
    logic [7:0] target_duty;
    logic [7:0] duty_out;
    logic       busy;
    logic       done;
    logic [1:0] state_dbg;   // raw FSM state, for checkers and bring-up

    modport master (
        output ramp_en,
        output target_duty,
        input  duty_out,
        input  busy,
        input  done,
        input  state_dbg
    );

    modport slave (
        input  ramp_en,
        input  target_duty,
        output duty_out,
        output busy,
        output done,
        output state_dbg
    );
endinterface

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: slew-rate limiter between the SPI duty register and the PWM
// peripheral. With ramp_en=1 the applied duty walks toward target_duty by
// STEP_SIZE LSBs every STEP_CYCLES clocks, never overshooting; with ramp_en=0
// the target passes straight through one cycle later.
//
// Optional build macro RAMP_FAST_OFF_EN: when defined, a target of 0x00 with
// ramp_en=1 shuts the output off on the next edge instead of ramping down.
module pwm_duty_ramp #(
    parameter int STEP_CYCLES = 1000,  // clk cycles between duty steps (>=1)
    parameter int STEP_SIZE   = 1      // duty LSBs per step (1..255)
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_duty_ramp_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } state_t;

    localparam int            PW    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PW-1:0] LAST  = PW'(STEP_CYCLES - 1);
    localparam logic [8:0]    STEP9 = 9'(STEP_SIZE);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    duty_q,  duty_d;
    logic          done_q,  done_d;

    // 9-bit distance to target and the clamped step, so a step can never
    // carry past 0xFF, borrow below 0x00, or jump over the target.
    logic [8:0] tgt9, duty9, gap9, step9;
    logic       landed;

    // Distance and clamped step toward the target.
    always_comb begin
        tgt9   = {1'b0, bus.target_duty};
        duty9  = {1'b0, duty_q};
        gap9   = (tgt9 > duty9) ? (tgt9 - duty9) : (duty9 - tgt9);
        step9  = (gap9 < STEP9) ? gap9 : STEP9;
        landed = (step9 == gap9);
    end

    // Next-state, prescaler, duty and done decode.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        duty_d  = duty_q;
        done_d  = 1'b0;

        if (!bus.ramp_en) begin
            // Bypass: follow the target, abandon any ramp silently.
            duty_d  = bus.target_duty;
            state_d = IDLE;
            presc_d = '0;
`ifdef RAMP_FAST_OFF_EN
        end else if (bus.target_duty == 8'h00) begin
            // Immediate shutdown; report completion only if we actually moved.
            duty_d  = 8'h00;
            state_d = IDLE;
            presc_d = '0;
            done_d  = (duty_q != 8'h00);
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.target_duty > duty_q) begin
                        state_d = RAMP_UP;
                        presc_d = '0;
                    end else if (bus.target_duty < duty_q) begin
                        state_d = RAMP_DOWN;
                        presc_d = '0;
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (bus.target_duty == duty_q) begin
                        // Target moved onto us: finish without a step.
                        state_d = IDLE;
                        presc_d = '0;
                        done_d  = 1'b1;
                    end else if ((bus.target_duty > duty_q) != (state_q == RAMP_UP)) begin
                        // Target crossed to the other side: reverse, restart timing.
                        state_d = (bus.target_duty > duty_q) ? RAMP_UP : RAMP_DOWN;
                        presc_d = '0;
                    end else if (presc_q == LAST) begin
                        presc_d = '0;
                        duty_d  = (state_q == RAMP_UP) ? (duty_q + step9[7:0])
                                                       : (duty_q - step9[7:0]);
                        if (landed) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                end
            endcase
        end
    end

    // State register; reset aborts any ramp at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            duty_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            duty_q  <= duty_d;
            done_q  <= done_d;
        end
    end

    assign bus.duty_out  = duty_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp: directed bench for pwm_duty_ramp with STEP_CYCLES=4 and
// STEP_SIZE=16. A behavioural model predicts duty/busy/done every edge into
// exp_q; a compare process checks them each falling edge. Directed checks with
// literal values pin the model. Honours RAMP_FAST_OFF_EN when defined.
module tb_pwm_duty_ramp;

    localparam int SC = 4;
    localparam int SS = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pwm_duty_ramp_if bus_if ();

    pwm_duty_ramp #(.STEP_CYCLES(SC), .STEP_SIZE(SS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Clock and reset block.
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: {done, busy, duty} expected after each edge.
    logic [9:0] exp_q[$];
    logic [9:0] cmp_exp;
    logic [9:0] cmp_act;

    // Model state: duty level, whether a ramp is active, its direction and the
    // number of edges since the last step (or ramp start).
    int m_duty;
    int m_tgt;
    int m_gap;
    int m_cnt;
    bit m_active;
    bit m_up;
    bit m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_duty   = 0;
            m_active = 0;
            m_up     = 0;
            m_cnt    = 0;
            m_done   = 0;
            exp_q.delete();
        end else begin
            m_tgt  = int'(bus_if.target_duty);
            m_done = 0;
            if (!bus_if.ramp_en) begin
                m_duty   = m_tgt;
                m_active = 0;
`ifdef RAMP_FAST_OFF_EN
            end else if (m_tgt == 0) begin
                m_done   = (m_duty != 0);
                m_duty   = 0;
                m_active = 0;
`endif
            end else if (!m_active) begin
                if (m_tgt != m_duty) begin
                    m_active = 1;
                    m_up     = (m_tgt > m_duty);
                    m_cnt    = 0;
                end
            end else if (m_tgt == m_duty) begin
                m_active = 0;
                m_done   = 1;
            end else if ((m_tgt > m_duty) != m_up) begin
                m_up  = ~m_up;
                m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
                if (m_cnt == SC) begin
                    m_cnt = 0;
                    m_gap = m_up ? (m_tgt - m_duty) : (m_duty - m_tgt);
                    if (m_gap > SS) m_gap = SS;
                    m_duty = m_up ? (m_duty + m_gap) : (m_duty - m_gap);
                    if (m_duty == m_tgt) begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end
            exp_q.push_back({m_done, m_active, 8'(m_duty)});
        end
    end

    // Compare process: every falling edge.
    always @(negedge clk) begin
        cmp_act = {bus_if.done, bus_if.busy, bus_if.duty_out};
        if (!rst_n) begin
            n_vec = n_vec + 1;
            if (cmp_act !== 10'h000) begin
                n_err = n_err + 1;
                $display("FAIL cycle_reset t=%0t actual={done,busy,duty}=%03h required=000", $time, cmp_act);
            end
        end else if (exp_q.size() > 0) begin
            cmp_exp = exp_q.pop_front();
            n_vec = n_vec + 1;
            if (cmp_act !== cmp_exp) begin
                n_err = n_err + 1;
                $display("FAIL cycle_model t=%0t actual={done,busy,duty}=%03h required=%03h", $time, cmp_act, cmp_exp);
            end
        end
    end

    // Driver tasks.
    task automatic drive(input bit en, input logic [7:0] tgt);
        bus_if.ramp_en     = en;
        bus_if.target_duty = tgt;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec = n_vec + 1;
        if (act !== req) begin
            n_err = n_err + 1;
            $display("FAIL %s t=%0t actual=%02h required=%02h", name, $time, act, req);
        end
    endtask

    task automatic chk_st(input string name, input logic [7:0] duty, input bit busy, input bit done);
        chk({name, "_duty"}, bus_if.duty_out, duty);
        chk({name, "_busy"}, {7'd0, bus_if.busy}, {7'd0, busy});
        chk({name, "_done"}, {7'd0, bus_if.done}, {7'd0, done});
    endtask

    // Watchdog: every wait below is a fixed cycle count, this bounds the run.
    initial begin
        #100000;
        n_err = n_err + 1;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(1'b1, 8'h00);
        rst_n = 1'b0;
        wait_neg(2);
        chk_st("reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        wait_neg(1);

        // Ramp up 0x00 -> 0x40 in four steps of 16.
        drive(1'b1, 8'h40);
        wait_neg(1);  chk_st("up_entry", 8'h00, 1'b1, 1'b0);
        wait_neg(3);  chk_st("up_wait", 8'h00, 1'b1, 1'b0);
        wait_neg(1);  chk_st("up_s1", 8'h10, 1'b1, 1'b0);
        wait_neg(4);  chk_st("up_s2", 8'h20, 1'b1, 1'b0);
        wait_neg(4);  chk_st("up_s3", 8'h30, 1'b1, 1'b0);
        wait_neg(4);  chk_st("up_s4", 8'h40, 1'b0, 1'b1);
        wait_neg(1);  chk_st("up_after", 8'h40, 1'b0, 1'b0);

        // No overshoot: 0x00 -> 0x25 lands on a short final step.
        drive(1'b0, 8'h00);
        wait_neg(1);  chk_st("byp_zero", 8'h00, 1'b0, 1'b0);
        drive(1'b1, 8'h25);
        wait_neg(1);  chk_st("short_entry", 8'h00, 1'b1, 1'b0);
        wait_neg(4);  chk_st("short_s1", 8'h10, 1'b1, 1'b0);
        wait_neg(4);  chk_st("short_s2", 8'h20, 1'b1, 1'b0);
        wait_neg(4);  chk_st("short_s3", 8'h25, 1'b0, 1'b1);
        wait_neg(1);  chk_st("short_after", 8'h25, 1'b0, 1'b0);

        // No wrap at the top: 0xF8 -> 0xFF in one clamped step.
        drive(1'b0, 8'hF8);
        wait_neg(1);  chk_st("byp_f8", 8'hF8, 1'b0, 1'b0);
        drive(1'b1, 8'hFF);
        wait_neg(1);  chk_st("top_entry", 8'hF8, 1'b1, 1'b0);
        wait_neg(4);  chk_st("top_s1", 8'hFF, 1'b0, 1'b1);

        // Reverse mid-ramp: toward 0x80, at 0x30 retarget to 0x10.
        drive(1'b0, 8'h00);
        wait_neg(1);
        drive(1'b1, 8'h80);
        wait_neg(1);  chk_st("rev_entry", 8'h00, 1'b1, 1'b0);
        wait_neg(12); chk_st("rev_at30", 8'h30, 1'b1, 1'b0);
        drive(1'b1, 8'h10);
        wait_neg(1);  chk_st("rev_switch", 8'h30, 1'b1, 1'b0);
        wait_neg(3);  chk_st("rev_wait", 8'h30, 1'b1, 1'b0);
        wait_neg(1);  chk_st("rev_s1", 8'h20, 1'b1, 1'b0);
        wait_neg(4);  chk_st("rev_s2", 8'h10, 1'b0, 1'b1);
        wait_neg(1);  chk_st("rev_after", 8'h10, 1'b0, 1'b0);

        // Bypass passthrough, then drop ramp_en mid-ramp.
        drive(1'b0, 8'hC8);
        wait_neg(1);  chk_st("byp_c8", 8'hC8, 1'b0, 1'b0);
        drive(1'b1, 8'h20);
        wait_neg(1);  chk_st("abort_entry", 8'hC8, 1'b1, 1'b0);
        wait_neg(4);  chk_st("abort_s1", 8'hB8, 1'b1, 1'b0);
        wait_neg(2);
        drive(1'b0, 8'h20);
        wait_neg(1);  chk_st("abort_snap", 8'h20, 1'b0, 1'b0);
        wait_neg(1);  chk_st("abort_after", 8'h20, 1'b0, 1'b0);

        // Ramp enabled with target already equal: stay idle, no done.
        drive(1'b1, 8'h20);
        wait_neg(3);  chk_st("equal_idle", 8'h20, 1'b0, 1'b0);

        // Ramp to zero from 0x90.
        drive(1'b0, 8'h90);
        wait_neg(1);  chk_st("byp_90", 8'h90, 1'b0, 1'b0);
        drive(1'b1, 8'h00);
`ifdef RAMP_FAST_OFF_EN
        wait_neg(1);  chk_st("fastoff", 8'h00, 1'b0, 1'b1);
        wait_neg(1);  chk_st("fastoff_after", 8'h00, 1'b0, 1'b0);
`else
        wait_neg(1);  chk_st("down0_entry", 8'h90, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            wait_neg(4);
            chk_st("down0_step", 8'(8'h90 - 16 * i), (i != 9), (i == 9));
        end
`endif

        // Asynchronous reset in the middle of a ramp from 0x55.
        drive(1'b0, 8'h55);
        wait_neg(1);  chk_st("byp_55", 8'h55, 1'b0, 1'b0);
        drive(1'b1, 8'hA0);
        wait_neg(1);  chk_st("rst_entry", 8'h55, 1'b1, 1'b0);
        wait_neg(2);
        #2 rst_n = 1'b0;
        #1 chk_st("async_rst", 8'h00, 1'b0, 1'b0);
        wait_neg(1);
        rst_n = 1'b1;
        wait_neg(1);  chk_st("post_rst_entry", 8'h00, 1'b1, 1'b0);
        wait_neg(4);  chk_st("post_rst_s1", 8'h10, 1'b1, 1'b0);
        wait_neg(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
